arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
Client-side end of the two-way request/grant arbitration handshake. Accepts a job of LEN beats from local logic and raises a request to the arbiter. Once the grant arrives, it holds ownership for exactly LEN cycles, then releases. Handles grant timeout, grant loss (pre-emption) and a mandatory idle holdoff, so one arbiter slot is driven by one instance.

Parameters:
LEN_W, 4, width of len input and beat counter; max burst 2^LEN_W-1 beats
TIMEOUT, 8, max cycles req may stay high without grant (>=1)
HOLDOFF, 2, idle cycles forced after release before a new request (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  job strobe, sampled only in IDLE
len  input  LEN_W  beat count for the job, sampled with start
grant  input  1  grant from arbiter (registered at arbiter, one-cycle latency after req)
req  output  1  request to arbiter
busy  output  1  high in any state other than IDLE
active  output  1  high while owning the resource (one cycle per beat)
beat  output  LEN_W  index of current beat while active, else 0
done  output  1  one-cycle pulse: burst completed normally
timed_out  output  1  one-cycle pulse: grant never arrived
aborted  output  1  one-cycle pulse: grant lost mid-burst

Behaviour:
- All outputs registered. Reset asynchronously forces state IDLE and all outputs and counters to 0 immediately, including mid-burst. The first request after reset deassertion needs a fresh start.
- States: IDLE, REQ, OWN, HOLD.
- IDLE: req=0, busy=0. On an edge with start=1 and len!=0: latch len_q=len, wait_cnt=0, go to REQ. start with len=0 is ignored, with no pulse and no state change.
- REQ: req=1, busy=1, active=0.
  - Edge with grant=1: go to OWN, beat=0.
  - Edge with grant=0: wait_cnt++. If wait_cnt==TIMEOUT-1, go to HOLD with timed_out=1 for one cycle, so req is high for exactly TIMEOUT cycles.
  - grant=1 on the timeout edge wins: go to OWN, no timed_out.
- OWN: req=1, active=1.
  - Edge with grant=1 and beat<len_q-1: beat++.
  - Edge with grant=1 and beat==len_q-1: go to HOLD, done=1 for one cycle, active=0, beat=0. active is therefore high for exactly len_q cycles.
  - Edge with grant=0 in OWN: go to HOLD, aborted=1 for one cycle, no done, beat=0.
- HOLD: req=0, busy=1, active=0. Stays exactly HOLDOFF cycles (hold_cnt), then returns to IDLE.
- Pulse timing: done, timed_out and aborted assert in the first HOLD cycle. They are mutually exclusive and never high for two consecutive cycles.
- start is ignored outside IDLE: no queuing, and len is not re-sampled.
- grant outside REQ/OWN is ignored. A stale grant in HOLD or IDLE must not cause any state change.
- Latency, for start sampled at edge k with the arbiter granting immediately:
  - req high from k+1.
  - grant sampled high at edge k+2.
  - active from k+2 to k+2+len-1.
  - done in the cycle after the last beat.

Test Plan:
- Reset mid-burst: len=5, assert reset during beat 2 -> req, active, busy, beat and pulses go to 0 without waiting for a clock; after release, state is IDLE and grant=1 causes no req.
- Normal burst: len=3, grant follows req one cycle later -> req high 4 cycles; active high exactly 3 cycles with beat 0,1,2; done single pulse; req low for 2 HOLD cycles; busy low afterwards.
- Timeout: TIMEOUT=8, len=4, grant held 0 -> req high exactly 8 cycles, timed_out pulses once, active never asserts, busy drops after HOLDOFF.
- Grant on timeout edge: grant first high on the 8th REQ cycle -> OWN entered, no timed_out, full 4-beat burst, done pulses.
- Pre-emption: len=6, grant drops after beat 2 -> aborted pulses once, done stays 0, req drops, beat returns to 0.
- Ignored inputs: start with len=0 -> no req. start=1 held continuously during a burst -> exactly one burst per IDLE entry, with at least 2 cycles of req=0 between bursts. grant=1 while IDLE -> no effect.

Source files
------------

// File: rtl/arb_requester.sv
// arb_requester
// Client side of a request/grant arbitration handshake. A job of `len` beats
// is accepted from local logic, a request is raised to the arbiter, and once
// the grant arrives the resource is owned for exactly len_q cycles. After the
// request ends (normal completion, grant timeout or grant loss), the block
// sits in a fixed idle holdoff before it accepts another job.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   start      job strobe, sampled only in IDLE
//   len        beat count for the job, sampled with start (0 = ignored)
//   grant      grant from the arbiter (registered, one cycle after req)
//   req        request to the arbiter
//   busy       high in every state except IDLE
//   active     high while owning the resource, one cycle per beat
//   beat       index of the current beat while active, else 0
//   done       one-cycle pulse: burst completed normally
//   timed_out  one-cycle pulse: grant never arrived
//   aborted    one-cycle pulse: grant lost mid-burst
//
// All outputs are registered. They are computed from the next-state values,
// so they line up with the state they describe.
module arb_requester #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             grant,
  output logic             req,
  output logic             busy,
  output logic             active,
  output logic [LEN_W-1:0] beat,
  output logic             done,
  output logic             timed_out,
  output logic             aborted
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [LEN_W-1:0]  BEAT_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_HOLD
  } state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   len_q, len_q_n;
  logic [LEN_W-1:0]   beat_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic               req_n, busy_n, active_n;
  logic               done_n, timed_out_n, aborted_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      wait_cnt  <= '0;
      hold_cnt  <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      active    <= 1'b0;
      beat      <= '0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_q_n;
      wait_cnt  <= wait_cnt_n;
      hold_cnt  <= hold_cnt_n;
      req       <= req_n;
      busy      <= busy_n;
      active    <= active_n;
      beat      <= beat_n;
      done      <= done_n;
      timed_out <= timed_out_n;
      aborted   <= aborted_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_q_n     = len_q;
    wait_cnt_n  = wait_cnt;
    hold_cnt_n  = hold_cnt;
    beat_n      = '0;
    done_n      = 1'b0;
    timed_out_n = 1'b0;
    aborted_n   = 1'b0;

    case (state)
      S_IDLE: begin
        // A zero-length job is dropped silently.
        if (start && (len != '0)) begin
          len_q_n    = len;
          wait_cnt_n = '0;
          state_n    = S_REQ;
        end
      end

      S_REQ: begin
        // A grant on the final waiting edge takes priority over the timeout.
        if (grant) begin
          state_n = S_OWN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n     = S_HOLD;
          hold_cnt_n  = '0;
          timed_out_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end

      S_OWN: begin
        if (!grant) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
          aborted_n  = 1'b1;
        end else if (beat == (len_q - BEAT_ONE)) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
          done_n     = 1'b1;
        end else begin
          beat_n = beat + BEAT_ONE;
        end
      end

      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = S_IDLE;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    req_n    = (state_n == S_REQ) || (state_n == S_OWN);
    busy_n   = (state_n != S_IDLE);
    active_n = (state_n == S_OWN);
  end

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned HOLDOFF = 2;

  logic             clock;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             grant;
  logic             req;
  logic             busy;
  logic             active;
  logic [LEN_W-1:0] beat;
  logic             done;
  logic             timed_out;
  logic             aborted;

  arb_requester #(
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .grant    (grant),
    .req      (req),
    .busy     (busy),
    .active   (active),
    .beat     (beat),
    .done     (done),
    .timed_out(timed_out),
    .aborted  (aborted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed output bundle: {req, busy, active, beat[3:0], done, timed_out, aborted}
  logic [9:0] obs;
  assign obs = {req, busy, active, beat, done, timed_out, aborted};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [9:0] mk(input bit r, input bit b, input bit a,
                                    input int bt, input bit d, input bit t,
                                    input bit ab);
    return {r, b, a, 4'(bt), d, t, ab};
  endfunction

  task automatic check(input string nm, input int idx, input logic [9:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s[%0d]: got req,busy,act,beat,done,to,ab=%b required %b",
               nm, idx, obs, expv);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  // Expected trace for one job, built from the handshake rules: index e is
  // the output seen just after edge e, edge 0 being the edge that takes start.
  logic [9:0] exp_tr [0:63];
  int         tr_last;

  task automatic build_trace(input int l, input logic [63:0] gp);
    int g;
    int h;
    int kind;  // 0 done, 1 timeout, 2 abort
    g = 0;
    h = 0;
    kind = 1;
    for (int i = 0; i < 64; i++) exp_tr[i] = '0;
    exp_tr[0] = mk(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= int'(TIMEOUT); i++)
      if (g == 0 && gp[i]) g = i;
    if (g == 0) begin
      for (int e = 1; e < int'(TIMEOUT); e++) exp_tr[e] = mk(1, 1, 0, 0, 0, 0, 0);
      h = TIMEOUT;
      kind = 1;
    end else begin
      for (int e = 1; e < g; e++) exp_tr[e] = mk(1, 1, 0, 0, 0, 0, 0);
      exp_tr[g] = mk(1, 1, 1, 0, 0, 0, 0);
      for (int b = 1; b <= l; b++) begin
        if (h == 0) begin
          if (!gp[g+b]) begin
            h = g + b;
            kind = 2;
          end else if (b == l) begin
            h = g + b;
            kind = 0;
          end else begin
            exp_tr[g+b] = mk(1, 1, 1, b, 0, 0, 0);
          end
        end
      end
    end
    for (int i = 0; i < int'(HOLDOFF); i++)
      exp_tr[h+i] = mk(0, 1, 0, 0, (i == 0) && (kind == 0),
                       (i == 0) && (kind == 1), (i == 0) && (kind == 2));
    exp_tr[h+int'(HOLDOFF)] = '0;
    tr_last = h + int'(HOLDOFF);
  endtask

  int rq_cnt, act_cnt, dn_cnt, to_cnt, ab_cnt;

  task automatic tally();
    rq_cnt  += int'(req);
    act_cnt += int'(active);
    dn_cnt  += int'(done);
    to_cnt  += int'(timed_out);
    ab_cnt  += int'(aborted);
  endtask

  // Runs one job from IDLE; gp[e] is the grant seen at edge e. Start and len
  // are scrambled during the job (or start held high) to show they are ignored.
  task automatic run_job(input string nm, input int l, input logic [63:0] gp,
                         input bit hold_start);
    build_trace(l, gp);
    rq_cnt = 0; act_cnt = 0; dn_cnt = 0; to_cnt = 0; ab_cnt = 0;
    start = 1'b1;
    len   = 4'(l);
    grant = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    check(nm, 0, exp_tr[0]);
    tally();
    for (int e = 1; e <= tr_last; e++) begin
      start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      len   = 4'($urandom);
      grant = gp[e];
      @(posedge clock); #1;
      check(nm, e, exp_tr[e]);
      tally();
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
      len   = '0;
      grant = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      check(nm, i, '0);
    end
    start = 1'b0;
  endtask

  typedef struct packed {
    logic       start;
    logic [3:0] len;
    logic       grant;
    logic [9:0] expv;
  } vec_t;

  vec_t tbl [0:20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal burst len=3 with an immediate grant, zero-length start, a
    // len=2 burst with start held and len changing, then a single-beat burst.
    tbl[0]  = '{1'b1, 4'd3, 1'b0, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 4'd0, 1'b1, mk(1, 1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 4'd0, 1'b1, mk(1, 1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 4'd0, 1'b1, mk(1, 1, 1, 2, 0, 0, 0)};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, mk(0, 1, 0, 0, 1, 0, 0)};
    tbl[5]  = '{1'b0, 4'd0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 4'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 4'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1'b0, 4'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 4'd2, 1'b0, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b1, 4'd9, 1'b0, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b1, 4'd7, 1'b1, mk(1, 1, 1, 0, 0, 0, 0)};
    tbl[12] = '{1'b1, 4'd7, 1'b1, mk(1, 1, 1, 1, 0, 0, 0)};
    tbl[13] = '{1'b1, 4'd7, 1'b1, mk(0, 1, 0, 0, 1, 0, 0)};
    tbl[14] = '{1'b1, 4'd7, 1'b0, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[15] = '{1'b1, 4'd1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{1'b1, 4'd1, 1'b0, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[17] = '{1'b0, 4'd0, 1'b1, mk(1, 1, 1, 0, 0, 0, 0)};
    tbl[18] = '{1'b0, 4'd0, 1'b1, mk(0, 1, 0, 0, 1, 0, 0)};
    tbl[19] = '{1'b0, 4'd0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[20] = '{1'b0, 4'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0)};

    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    grant = 1'b0;
    #1;
    check("reset_state", 0, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      start = tbl[i].start;
      len   = tbl[i].len;
      grant = tbl[i].grant;
      @(posedge clock); #1;
      check("table", i, tbl[i].expv);
    end
    start = 1'b0;
    grant = 1'b0;

    // Reset in the middle of a len=5 burst, during beat 2.
    start = 1'b1; len = 4'd5; grant = 1'b0;
    @(posedge clock); #1;
    check("rst_seq", 0, mk(1, 1, 0, 0, 0, 0, 0));
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      grant = 1'b1;
      @(posedge clock); #1;
      check("rst_seq", b + 1, mk(1, 1, 1, b, 0, 0, 0));
    end
    #2 reset = 1'b1;
    #1 check("rst_async", 0, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      grant = 1'b1;
      @(posedge clock); #1;
      check("rst_after", i, '0);
    end
    grant = 1'b0;

    // Grant never arrives.
    run_job("timeout", 4, 64'd0, 1'b0);
    check_int("timeout_req_cycles", rq_cnt, TIMEOUT);
    check_int("timeout_pulses", to_cnt, 1);
    check_int("timeout_active", act_cnt, 0);

    // Grant first seen on the last waiting edge.
    run_job("grant_last", 4, ~64'd0 << TIMEOUT, 1'b0);
    check_int("grant_last_to", to_cnt, 0);
    check_int("grant_last_active", act_cnt, 4);
    check_int("grant_last_done", dn_cnt, 1);

    // Grant lost after beat 2 of a 6-beat burst.
    run_job("preempt", 6, 64'b11100, 1'b0);
    check_int("preempt_aborted", ab_cnt, 1);
    check_int("preempt_done", dn_cnt, 0);
    check_int("preempt_active", act_cnt, 3);

    // start held high across back-to-back jobs, and maximum length.
    run_job("held_a", 3, ~64'd0 << 1, 1'b1);
    run_job("held_b", 15, ~64'd0 << 2, 1'b1);
    check_int("max_len_active", act_cnt, 15);
    idle_cycles("idle", 4);

    for (int k = 0; k < 250; k++) begin
      int l, mode, d, cut;
      logic [63:0] gp;
      l    = $urandom_range(1, 15);
      mode = $urandom_range(0, 3);
      d    = $urandom_range(1, TIMEOUT + 2);
      case (mode)
        0: gp = ~64'd0 << d;
        1: begin
          gp = ~64'd0 << d;
          cut = d + $urandom_range(1, l);
          gp[cut] = 1'b0;
        end
        2: gp = {$urandom, $urandom} | {$urandom, $urandom};
        default: gp = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      run_job("rand", l, gp, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles("rand_idle", $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
